// File: rtl/run_ctrl_pkg.sv
// Shared state encoding and default configuration for the run controller.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    LAUNCH,
    RUN,
    DUMP_RD,
    DUMP_OUT,
    DONE
  } state_t;

  localparam int DEF_DW        = 8;
  localparam int DEF_AW        = 8;
  localparam int DEF_CLR_BASE  = 0;
  localparam int DEF_CLR_LEN   = 256;
  localparam int DEF_LOAD_BASE = 128;
  localparam int DEF_LOAD_LEN  = 8;
  localparam int DEF_DUMP_BASE = 5;
  localparam int DEF_DUMP_LEN  = 4;
  localparam int DEF_TW        = 16;

endpackage

// File: rtl/run_ctrl_timer.sv
// Saturating RUN-cycle counter; o_hit flags the cycle whose increment reaches the limit.
module run_timer
  import run_ctrl_pkg::*;
#(
  parameter int TW = DEF_TW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_en,
  input  logic [TW-1:0] i_lim,
  output logic [TW-1:0] o_count,
  output logic          o_hit
);

  logic [TW-1:0] r_count;
  logic [TW:0]   w_next_ext;

  // One extra bit so a saturated counter can never alias onto the limit.
  assign w_next_ext = {1'b0, r_count} + {{TW{1'b0}}, 1'b1};
  assign o_hit      = i_en && (i_lim != '0) && (w_next_ext == {1'b0, i_lim});
  assign o_count    = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= w_next_ext[TW-1:0];
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer: clear DM, preload, launch core, wait Ack/timeout, dump results.
// Optional dump checksum output Csum is built when RUN_CTRL_CSUM_EN is defined.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int AW        = DEF_AW,
  parameter int CLR_BASE  = DEF_CLR_BASE,
  parameter int CLR_LEN   = DEF_CLR_LEN,
  parameter int LOAD_BASE = DEF_LOAD_BASE,
  parameter int LOAD_LEN  = DEF_LOAD_LEN,
  parameter int DUMP_BASE = DEF_DUMP_BASE,
  parameter int DUMP_LEN  = DEF_DUMP_LEN,
  parameter int TW        = DEF_TW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Go,
  input  logic [TW-1:0] TimeoutLim,
  input  logic          LdValid,
  input  logic [DW-1:0] LdData,
  output logic          LdReady,
  output logic          CoreStart,
  input  logic          CoreAck,
  output logic          MemWrEn,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWrData,
  input  logic [DW-1:0] MemRdData,
  output logic          DumpValid,
  output logic [DW-1:0] DumpData,
  input  logic          DumpReady,
  output logic          Busy,
  output logic          Done,
  output logic          TimedOut,
`ifdef RUN_CTRL_CSUM_EN
  output logic [DW-1:0] Csum,
`endif
  output logic [TW-1:0] CycleCount,
  output state_t        DbgState
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CLR_LAST  = CW'((CLR_LEN > 0) ? CLR_LEN - 1 : 0);
  localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_LEN - 1);
  localparam logic [CW-1:0] DUMP_LAST = CW'(DUMP_LEN - 1);

  if (LOAD_BASE + LOAD_LEN > (1 << AW)) begin : g_load_chk
    $error("run_ctrl: load window exceeds DM depth");
  end
  if (DUMP_BASE + DUMP_LEN > (1 << AW)) begin : g_dump_chk
    $error("run_ctrl: dump window exceeds DM depth");
  end

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_idx;
  logic          r_done, r_timed_out;
  logic          w_go, w_hit;
  logic [AW-1:0] w_dump_addr;

  assign w_dump_addr = AW'(DUMP_BASE) + r_idx[AW-1:0];

  run_timer #(.TW(TW)) u_timer (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_clear (w_go),
    .i_en    (r_state == RUN),
    .i_lim   (TimeoutLim),
    .o_count (CycleCount),
    .o_hit   (w_hit)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    LdReady     = 1'b0;
    CoreStart   = 1'b1;
    MemWrEn     = 1'b0;
    MemAddr     = '0;
    MemWrData   = '0;
    DumpValid   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (Go) begin
          w_go        = 1'b1;
          w_state_nxt = (CLR_LEN == 0) ? LOAD : CLEAR;
        end
      end
      CLEAR: begin
        MemWrEn = 1'b1;
        MemAddr = AW'(CLR_BASE) + r_idx[AW-1:0];
        if (r_idx == CLR_LAST) w_state_nxt = LOAD;
      end
      LOAD: begin
        LdReady   = 1'b1;
        MemWrEn   = LdValid;
        MemAddr   = AW'(LOAD_BASE) + r_idx[AW-1:0];
        MemWrData = LdData;
        if (LdValid && (r_idx == LOAD_LAST)) w_state_nxt = LAUNCH;
      end
      LAUNCH: w_state_nxt = RUN;
      RUN: begin
        CoreStart = 1'b0;
        if (CoreAck || w_hit) w_state_nxt = DUMP_RD;
      end
      DUMP_RD: begin
        MemAddr     = w_dump_addr;
        w_state_nxt = DUMP_OUT;
      end
      DUMP_OUT: begin
        // Address stays put so the DM's registered read output holds the word.
        MemAddr   = w_dump_addr;
        DumpValid = 1'b1;
        if (DumpReady) w_state_nxt = (r_idx == DUMP_LAST) ? DONE : DUMP_RD;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_idx       <= '0;
      r_done      <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_go) begin
            r_idx       <= '0;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
          end
        end
        CLEAR: r_idx <= (r_idx == CLR_LAST) ? '0 : r_idx + CW'(1);
        LOAD: begin
          if (LdValid) r_idx <= (r_idx == LOAD_LAST) ? '0 : r_idx + CW'(1);
        end
        RUN: begin
          if (!CoreAck && w_hit) r_timed_out <= 1'b1;
        end
        DUMP_OUT: begin
          if (DumpReady) begin
            r_idx <= (r_idx == DUMP_LAST) ? '0 : r_idx + CW'(1);
            if (r_idx == DUMP_LAST) r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RUN_CTRL_CSUM_EN
  logic [DW-1:0] r_csum;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                                    r_csum <= '0;
    else if (w_go)                                r_csum <= '0;
    else if ((r_state == DUMP_OUT) && DumpReady)  r_csum <= r_csum + MemRdData;
  end
  assign Csum = r_csum;
`endif

  assign DumpData = (r_state == DUMP_OUT) ? MemRdData : '0;
  assign Busy     = (r_state != IDLE) && (r_state != DONE);
  assign Done     = r_done;
  assign TimedOut = r_timed_out;
  assign DbgState = r_state;

endmodule

// File: tb/tb_run_ctrl.sv
// Randomized self-checking bench for run_ctrl with a DM model and a core stub.
`timescale 1ns/1ps
module tb_run_ctrl;
  import run_ctrl_pkg::*;

  localparam int DW = 8, AW = 8, TW = 16;
  localparam int LOAD_BASE = 128, LOAD_LEN = 8, DUMP_BASE = 5, DUMP_LEN = 4;
  localparam int RUN_BOUND = 3000;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Go = 1'b0;
  logic [TW-1:0] TimeoutLim = '0;
  logic          LdValid = 1'b0;
  logic [DW-1:0] LdData = '0;
  logic          CoreAck = 1'b0;
  logic          DumpReady = 1'b0;
  logic          LdReady, CoreStart, MemWrEn, DumpValid, Busy, Done, TimedOut;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWrData, DumpData;
  logic [DW-1:0] mem_rd;
  logic [TW-1:0] CycleCount;
  state_t        DbgState;
`ifdef RUN_CTRL_CSUM_EN
  logic [DW-1:0] Csum;
`endif

  run_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Go(Go), .TimeoutLim(TimeoutLim),
    .LdValid(LdValid), .LdData(LdData), .LdReady(LdReady),
    .CoreStart(CoreStart), .CoreAck(CoreAck),
    .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemWrData(MemWrData), .MemRdData(mem_rd),
    .DumpValid(DumpValid), .DumpData(DumpData), .DumpReady(DumpReady),
    .Busy(Busy), .Done(Done), .TimedOut(TimedOut),
`ifdef RUN_CTRL_CSUM_EN
    .Csum(Csum),
`endif
    .CycleCount(CycleCount), .DbgState(DbgState)
  );

  always #5 Clk = ~Clk;

  // Data memory model with 1-cycle registered read, plus the core's own write port.
  logic [DW-1:0] mem [256];
  logic          scramble = 1'b1;
  logic          core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_data = '0;
  int unsigned   cyc_ctr = 0, ld_wr_cnt = 0, last_ld_edge = 0;

  always @(posedge Clk) begin
    cyc_ctr <= cyc_ctr + 1;
    if (scramble) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'($urandom);
    end else if (MemWrEn) begin
      mem[MemAddr] <= MemWrData;
      if (LdReady) begin
        ld_wr_cnt    <= ld_wr_cnt + 1;
        last_ld_edge <= cyc_ctr;
      end
    end else if (core_we) begin
      mem[core_addr] <= core_data;
    end
    mem_rd <= mem[MemAddr];
  end

  logic [46:0] outs_vec;
  assign outs_vec = {CoreStart, LdReady, MemWrEn, DumpValid, Busy, Done, TimedOut,
                     MemAddr, MemWrData, DumpData, CycleCount};
  localparam logic [46:0] EXP_IDLE = {1'b1, 46'd0};

  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] ld_vals [LOAD_LEN];
  logic [DW-1:0] res_vals [DUMP_LEN];
  logic [DW-1:0] got_q [$];
  int unsigned   r_ldw, r_fall, r_lastld;
  bit            r_stable_ok, r_bound_hit;
  int            bad_addr;
  logic [DW-1:0] bad_val, bad_exp;

  // Expected DM image: zero everywhere, preload window and the core's results on top.
  function automatic int mem_diff();
    logic [DW-1:0] e;
    int n;
    n = 0;
    for (int a = 0; a < 256; a++) begin
      e = '0;
      if (a >= LOAD_BASE && a < LOAD_BASE + LOAD_LEN) e = ld_vals[a - LOAD_BASE];
      if (a >= DUMP_BASE && a < DUMP_BASE + DUMP_LEN) e = res_vals[a - DUMP_BASE];
      if (mem[a] !== e) begin
        if (n == 0) begin bad_addr = a; bad_val = mem[a]; bad_exp = e; end
        n++;
      end
    end
    return n;
  endfunction

  // Drives one full run cycle by cycle; abort_at>0 asserts Reset in that RUN cycle.
  task automatic do_run(input logic [TW-1:0] lim, input int ack_at, input bit stall2,
                        input bit ld_toggle, input bit go_in_load, input bit rand_ready,
                        input int abort_at);
    int cyc, k, run_n, stall_cnt;
    bit seen_fall, pend, go_done, v;
    logic [DW-1:0] pend_data;
    int unsigned wr0;
    got_q.delete();
    r_stable_ok = 1; r_bound_hit = 0; seen_fall = 0; pend = 0; go_done = 0;
    stall_cnt = 0; k = 0; run_n = 0; cyc = 0; pend_data = '0;
    wr0 = ld_wr_cnt;
    TimeoutLim = lim;
    @(negedge Clk); Go = 1'b1;
    @(negedge Clk); Go = 1'b0;
    while (1) begin
      if (Done === 1'b1) break;
      if (cyc >= RUN_BOUND) begin r_bound_hit = 1; break; end
      Go = 1'b0;
      if (go_in_load && LdReady && k == 3 && !go_done) begin Go = 1'b1; go_done = 1; end
      if (LdReady && k < LOAD_LEN) begin
        v = ld_toggle ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
        LdValid = v;
        LdData  = ld_vals[k];
        if (v) k++;
      end else begin
        LdValid = 1'($urandom_range(0, 1));
        LdData  = 8'($urandom);
      end
      if (CoreStart === 1'b0) begin
        if (!seen_fall) begin seen_fall = 1; r_fall = cyc_ctr - 1; end
        run_n++;
        core_we = (run_n <= DUMP_LEN);
        if (run_n <= DUMP_LEN) begin
          core_addr = AW'(DUMP_BASE + run_n - 1);
          core_data = res_vals[run_n - 1];
        end
        CoreAck = (ack_at != 0 && run_n == ack_at);
        if (abort_at != 0 && run_n == abort_at) begin
          #2 Reset = 1'b1;
          #1 break;
        end
      end else begin
        core_we = 1'b0;
        CoreAck = 1'($urandom_range(0, 1));
      end
      if (DumpValid === 1'b1) begin
        if (pend && DumpData !== pend_data) r_stable_ok = 0;
        if (stall2 && got_q.size() == 1 && stall_cnt < 3) begin
          DumpReady = 1'b0; stall_cnt++;
        end else begin
          DumpReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (DumpReady) begin got_q.push_back(DumpData); pend = 0; end
        else begin pend = 1; pend_data = DumpData; end
      end else begin
        DumpReady = 1'($urandom_range(0, 1));
        pend = 0;
      end
      @(negedge Clk);
      cyc++;
    end
    LdValid = 1'b0; CoreAck = 1'b0; DumpReady = 1'b0; core_we = 1'b0; Go = 1'b0;
    r_ldw = ld_wr_cnt - wr0;
    r_lastld = last_ld_edge;
  endtask

  task automatic test_reset();
    #10 Reset = 1'b0;
    scramble = 1'b0;
    #1;
    n_cmp++;
    if (outs_vec !== EXP_IDLE) begin
      n_bad++; $display("FAIL reset_outs: got %h want %h", outs_vec, EXP_IDLE);
    end
    n_cmp++;
    if (DbgState !== IDLE) begin
      n_bad++; $display("FAIL reset_state: got %0d want %0d", DbgState, IDLE);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < LOAD_LEN; i++) ld_vals[i] = 8'($urandom);
    for (int i = 0; i < DUMP_LEN; i++) res_vals[i] = 8'($urandom);
    do_run(16'd5, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (r_bound_hit) begin n_bad++; $display("FAIL to_bound: run did not finish"); end
    n_cmp++;
    if (TimedOut !== 1'b1) begin n_bad++; $display("FAIL to_flag: got %b want 1", TimedOut); end
    n_cmp++;
    if (CycleCount !== 16'd5) begin n_bad++; $display("FAIL to_cycles: got %0d want 5", CycleCount); end
    n_cmp++;
    if (got_q.size() != DUMP_LEN) begin
      n_bad++; $display("FAIL to_dump_cnt: got %0d want %0d", got_q.size(), DUMP_LEN);
    end
    n_cmp++;
    if (Done !== 1'b1) begin n_bad++; $display("FAIL to_done: got %b want 1", Done); end
  endtask

  task automatic test_directed();
    logic [DW-1:0] ld_c [LOAD_LEN] = '{8'h0d, 8'h10, 8'h13, 8'h14, 8'h2a, 8'h37, 8'h4e, 8'h72};
    logic [DW-1:0] rs_c [DUMP_LEN] = '{8'h11, 8'h22, 8'h33, 8'h44};
    ld_vals = ld_c;
    res_vals = rs_c;
    do_run(16'd0, 20, 0, 0, 0, 0, 0);
    n_cmp++;
    if (r_bound_hit) begin n_bad++; $display("FAIL dir_bound: run did not finish"); end
    n_cmp++;
    if (mem_diff() != 0) begin
      n_bad++; $display("FAIL dir_dm: addr %0d got %h want %h", bad_addr, bad_val, bad_exp);
    end
    n_cmp++;
    if (r_ldw != LOAD_LEN) begin n_bad++; $display("FAIL dir_ld_writes: got %0d want %0d", r_ldw, LOAD_LEN); end
    n_cmp++;
    if (r_fall != r_lastld + 1) begin
      n_bad++; $display("FAIL dir_launch: start fell at edge %0d want %0d", r_fall, r_lastld + 1);
    end
    n_cmp++;
    if (got_q.size() != DUMP_LEN) begin
      n_bad++; $display("FAIL dir_dump_cnt: got %0d want %0d", got_q.size(), DUMP_LEN);
    end else begin
      for (int i = 0; i < DUMP_LEN; i++) begin
        n_cmp++;
        if (got_q[i] !== rs_c[i]) begin
          n_bad++; $display("FAIL dir_dump[%0d]: got %h want %h", i, got_q[i], rs_c[i]);
        end
      end
    end
    n_cmp++;
    if (CycleCount !== 16'd20) begin n_bad++; $display("FAIL dir_cycles: got %0d want 20", CycleCount); end
    n_cmp++;
    if ({TimedOut, Done, Busy} !== 3'b010) begin
      n_bad++; $display("FAIL dir_flags: to/done/busy got %b want 010", {TimedOut, Done, Busy});
    end
`ifdef RUN_CTRL_CSUM_EN
    n_cmp++;
    if (Csum !== 8'hAA) begin n_bad++; $display("FAIL dir_csum: got %h want aa", Csum); end
`endif
  endtask

  task automatic test_dump_stall();
    for (int i = 0; i < LOAD_LEN; i++) ld_vals[i] = 8'($urandom);
    for (int i = 0; i < DUMP_LEN; i++) res_vals[i] = 8'($urandom);
    do_run(16'd0, 9, 1, 0, 0, 0, 0);
    n_cmp++;
    if (!r_stable_ok || r_bound_hit) begin
      n_bad++; $display("FAIL stall_stable: stable %0d bound %0d want 1 0", r_stable_ok, r_bound_hit);
    end
    n_cmp++;
    if (got_q.size() != DUMP_LEN) begin
      n_bad++; $display("FAIL stall_cnt: got %0d want %0d", got_q.size(), DUMP_LEN);
    end else begin
      for (int i = 0; i < DUMP_LEN; i++) begin
        n_cmp++;
        if (got_q[i] !== res_vals[i]) begin
          n_bad++; $display("FAIL stall_dump[%0d]: got %h want %h", i, got_q[i], res_vals[i]);
        end
      end
    end
  endtask

  task automatic test_load_gaps();
    for (int i = 0; i < LOAD_LEN; i++) ld_vals[i] = 8'($urandom);
    for (int i = 0; i < DUMP_LEN; i++) res_vals[i] = 8'($urandom);
    do_run(16'd0, 6, 0, 1, 1, 1, 0);
    n_cmp++;
    if (r_ldw != LOAD_LEN || r_bound_hit) begin
      n_bad++; $display("FAIL gaps_writes: got %0d want %0d (bound %0d)", r_ldw, LOAD_LEN, r_bound_hit);
    end
    n_cmp++;
    if (mem_diff() != 0) begin
      n_bad++; $display("FAIL gaps_dm: addr %0d got %h want %h", bad_addr, bad_val, bad_exp);
    end
    n_cmp++;
    if (CycleCount !== 16'd6) begin n_bad++; $display("FAIL gaps_cycles: got %0d want 6", CycleCount); end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < LOAD_LEN; i++) ld_vals[i] = 8'($urandom);
    for (int i = 0; i < DUMP_LEN; i++) res_vals[i] = 8'($urandom);
    do_run(16'd0, 0, 0, 0, 0, 0, 7);
    n_cmp++;
    if (outs_vec !== EXP_IDLE) begin
      n_bad++; $display("FAIL abort_outs: got %h want %h", outs_vec, EXP_IDLE);
    end
    n_cmp++;
    if (DbgState !== IDLE) begin n_bad++; $display("FAIL abort_state: got %0d want %0d", DbgState, IDLE); end
    @(negedge Clk); Reset = 1'b0;
    for (int i = 0; i < LOAD_LEN; i++) ld_vals[i] = 8'($urandom);
    for (int i = 0; i < DUMP_LEN; i++) res_vals[i] = 8'($urandom);
    do_run(16'd0, 12, 0, 0, 0, 1, 0);
    n_cmp++;
    if (mem_diff() != 0 || r_bound_hit) begin
      n_bad++; $display("FAIL abort_rerun_dm: addr %0d got %h want %h", bad_addr, bad_val, bad_exp);
    end
    n_cmp++;
    if (CycleCount !== 16'd12) begin n_bad++; $display("FAIL abort_rerun_cycles: got %0d want 12", CycleCount); end
  endtask

  task automatic test_random();
    logic [TW-1:0] lim;
    int ack_at, exp_cc;
    bit exp_to;
    logic [DW-1:0] sum;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < LOAD_LEN; i++) ld_vals[i] = 8'($urandom);
      for (int i = 0; i < DUMP_LEN; i++) res_vals[i] = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       begin lim = 16'd0; ack_at = $urandom_range(4, 40); end
        1:       begin lim = 16'($urandom_range(4, 40)); ack_at = 0; end
        default: begin lim = 16'($urandom_range(4, 40)); ack_at = $urandom_range(4, 40); end
      endcase
      if (it == 0) begin lim = 16'd9; ack_at = 9; end
      if (ack_at != 0 && (lim == 0 || ack_at <= int'(lim))) begin exp_cc = ack_at; exp_to = 0; end
      else begin exp_cc = int'(lim); exp_to = 1; end
      do_run(lim, ack_at, 0, 0, 0, 1, 0);
      n_cmp++;
      if (r_bound_hit || CycleCount !== 16'(exp_cc) || TimedOut !== exp_to) begin
        n_bad++;
        $display("FAIL rnd%0d_run: cycles %0d to %b bound %0d want %0d %b 0",
                 it, CycleCount, TimedOut, r_bound_hit, exp_cc, exp_to);
      end
      n_cmp++;
      if (mem_diff() != 0) begin
        n_bad++; $display("FAIL rnd%0d_dm: addr %0d got %h want %h", it, bad_addr, bad_val, bad_exp);
      end
      sum = '0;
      n_cmp++;
      if (got_q.size() != DUMP_LEN) begin
        n_bad++; $display("FAIL rnd%0d_dump_cnt: got %0d want %0d", it, got_q.size(), DUMP_LEN);
      end else begin
        for (int i = 0; i < DUMP_LEN; i++) begin
          sum = sum + res_vals[i];
          n_cmp++;
          if (got_q[i] !== res_vals[i]) begin
            n_bad++; $display("FAIL rnd%0d_dump[%0d]: got %h want %h", it, i, got_q[i], res_vals[i]);
          end
        end
      end
`ifdef RUN_CTRL_CSUM_EN
      n_cmp++;
      if (Csum !== sum) begin n_bad++; $display("FAIL rnd%0d_csum: got %h want %h", it, Csum, sum); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_directed();
    test_dump_stall();
    test_load_gaps();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
